// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART core.
//   uart_tx_state_t / uart_rx_state_t : FSM state encodings
//   uart_data_t                       : default-width (8-bit) data word
//   UART_CLKS_PER_BIT_DEFAULT         : 100 MHz / 115200 baud divider
// Optional feature macro: UART_PARITY_EN adds the PARITY state to both FSMs.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned UART_DATA_W_DEFAULT       = 8;

    typedef logic [UART_DATA_W_DEFAULT-1:0] uart_data_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } uart_tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO used for the TX and RX queues.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_data (accepted when not full, or when a pop frees a slot)
//   i_pop     : consume head (ignored when empty)
//   o_data    : current head word
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
//   o_count   : number of entries held
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push on full is taken.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART, TX/RX FIFOs, internal baud counters, mid-bit RX sampling.
//   clk, rst              : clock, synchronous active-high reset
//   tx_data/valid/ready   : CPU push into TX FIFO
//   tx_busy               : TX FIFO non-empty or frame on the wire
//   rx_data/valid/ready   : FWFT head of RX FIFO, popped on valid && ready
//   rx_overrun            : sticky, frame dropped because RX FIFO full
//   frame_err, parity_err : 1-cycle pulses, offending frame discarded
//   uart_rx, uart_tx      : serial pins (uart_rx asynchronous, uart_tx idle high)
// Optional feature macro: UART_PARITY_EN (adds PARITY bit, parameter PARITY_ODD).
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned RX_DEPTH     = 16,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned STOP_BITS    = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit          PARITY_ODD   = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              frame_err,
    output logic              parity_err,
    input  logic              uart_rx,
    output logic              uart_tx
);

    localparam int unsigned   CW          = $clog2(CLKS_PER_BIT);
    localparam int unsigned   BW          = $clog2(DATA_W);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);

    // ---------------- TX ----------------
    logic [DATA_W-1:0]       w_txf_data;
    logic                    w_txf_full, w_txf_empty, w_tx_push, w_tx_pop, w_tx_tick, w_tx_load;
    logic [$clog2(TX_DEPTH):0] w_txf_count;
    uart_tx_state_t          r_tx_state, w_tx_state_n;
    logic [CW-1:0]           r_tx_cnt, w_tx_cnt_n;
    logic [BW-1:0]           r_tx_idx, w_tx_idx_n;
    logic [DATA_W-1:0]       r_tx_shift, w_tx_shift_n;
    logic                    r_tx_out, w_tx_out_n;
`ifdef UART_PARITY_EN
    logic                    r_tx_par, w_tx_par_n;
`endif

    assign tx_ready  = !w_txf_full;
    assign w_tx_push = tx_valid && !w_txf_full;
    assign tx_busy   = (w_txf_count != '0) || (r_tx_state != TX_IDLE);
    assign uart_tx   = r_tx_out;
    assign w_tx_tick = (r_tx_cnt == C_BIT_LAST);

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  (tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_txf_data),
        .o_full  (w_txf_full),
        .o_empty (w_txf_empty),
        .o_count (w_txf_count)
    );

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_idx_n   = r_tx_idx;
        w_tx_shift_n = r_tx_shift;
        w_tx_out_n   = r_tx_out;
        w_tx_load    = 1'b0;
        w_tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        w_tx_par_n   = r_tx_par;
`endif
        unique case (r_tx_state)
            TX_IDLE: begin
                w_tx_out_n = 1'b1;
                w_tx_load  = !w_txf_empty;
            end
            TX_START: if (w_tx_tick) begin
                w_tx_state_n = TX_DATA;
                w_tx_idx_n   = '0;
                w_tx_out_n   = r_tx_shift[0];
            end
            TX_DATA: if (w_tx_tick) begin
                if (r_tx_idx == C_DATA_LAST) begin
`ifdef UART_PARITY_EN
                    w_tx_state_n = TX_PARITY;
                    w_tx_out_n   = r_tx_par;
`else
                    w_tx_state_n = TX_STOP;
                    w_tx_out_n   = 1'b1;
                    w_tx_idx_n   = '0;
`endif
                end else begin
                    w_tx_idx_n   = r_tx_idx + BW'(1);
                    w_tx_shift_n = r_tx_shift >> 1;
                    w_tx_out_n   = r_tx_shift[1];
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (w_tx_tick) begin
                w_tx_state_n = TX_STOP;
                w_tx_out_n   = 1'b1;
                w_tx_idx_n   = '0;
            end
`endif
            TX_STOP: if (w_tx_tick) begin
                if (r_tx_idx == C_STOP_LAST) begin
                    // Chain straight into the next start bit: no idle gap.
                    w_tx_state_n = TX_IDLE;
                    w_tx_out_n   = 1'b1;
                    w_tx_load    = !w_txf_empty;
                end else begin
                    w_tx_idx_n = r_tx_idx + BW'(1);
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_pop     = 1'b1;
            w_tx_state_n = TX_START;
            w_tx_shift_n = w_txf_data;
            w_tx_out_n   = 1'b0;
`ifdef UART_PARITY_EN
            w_tx_par_n   = (^w_txf_data) ^ PARITY_ODD;
`endif
        end
        w_tx_cnt_n = (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_idx   <= w_tx_idx_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_out   <= w_tx_out_n;
`ifdef UART_PARITY_EN
            r_tx_par   <= w_tx_par_n;
`endif
        end
    end

    // ---------------- RX ----------------
    logic                    r_rx_meta, r_rx_sync;
    logic                    w_rxf_full, w_rxf_empty, w_rx_push, w_rx_pop, w_rx_tick;
    logic [$clog2(RX_DEPTH):0] w_rxf_count;
    uart_rx_state_t          r_rx_state, w_rx_state_n;
    logic [CW-1:0]           r_rx_cnt, w_rx_cnt_n;
    logic [BW-1:0]           r_rx_idx, w_rx_idx_n;
    logic [DATA_W-1:0]       r_rx_shift, w_rx_shift_n;
    logic                    r_frame_err, w_frame_err_n;
    logic                    r_rx_overrun;
`ifdef UART_PARITY_EN
    logic                    r_rx_par_bad, w_rx_par_bad_n;
    logic                    r_parity_err, w_parity_err_n;
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign w_rx_pop   = rx_ready && !w_rxf_empty;
    assign rx_valid   = (w_rxf_count != '0);
    assign rx_overrun = r_rx_overrun;
    assign frame_err  = r_frame_err;
    assign w_rx_tick  = (r_rx_cnt == C_BIT_LAST);

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_data  (rx_data),
        .o_full  (w_rxf_full),
        .o_empty (w_rxf_empty),
        .o_count (w_rxf_count)
    );

    always_comb begin
        w_rx_state_n  = r_rx_state;
        w_rx_idx_n    = r_rx_idx;
        w_rx_shift_n  = r_rx_shift;
        w_rx_push     = 1'b0;
        w_frame_err_n = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_bad_n = r_rx_par_bad;
        w_parity_err_n = 1'b0;
`endif
        unique case (r_rx_state)
            RX_IDLE: if (!r_rx_sync) w_rx_state_n = RX_START;
            // Half-bit re-check: a line already back high was a glitch.
            RX_START: if (r_rx_cnt == C_HALF_LAST) begin
                w_rx_state_n = r_rx_sync ? RX_IDLE : RX_DATA;
                w_rx_idx_n   = '0;
            end
            RX_DATA: if (w_rx_tick) begin
                w_rx_shift_n = {r_rx_sync, r_rx_shift[DATA_W-1:1]};
                if (r_rx_idx == C_DATA_LAST) begin
`ifdef UART_PARITY_EN
                    w_rx_state_n = RX_PARITY;
`else
                    w_rx_state_n = RX_STOP;
`endif
                end else begin
                    w_rx_idx_n = r_rx_idx + BW'(1);
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (w_rx_tick) begin
                w_rx_par_bad_n = r_rx_sync ^ (^r_rx_shift) ^ PARITY_ODD;
                w_rx_state_n   = RX_STOP;
            end
`endif
            RX_STOP: if (w_rx_tick) begin
                if (!r_rx_sync) begin
                    w_frame_err_n = 1'b1;
                    w_rx_state_n  = RX_WAIT_HIGH;
                end else begin
`ifdef UART_PARITY_EN
                    w_parity_err_n = r_rx_par_bad;
                    w_rx_push      = !r_rx_par_bad;
`else
                    w_rx_push      = 1'b1;
`endif
                    w_rx_state_n   = RX_IDLE;
                end
            end
            RX_WAIT_HIGH: if (r_rx_sync) w_rx_state_n = RX_IDLE;
            default: w_rx_state_n = RX_IDLE;
        endcase
        // Divider restarts on every state change so samples stay bit-centred.
        if (r_rx_state == RX_IDLE || r_rx_state == RX_WAIT_HIGH ||
            w_rx_state_n != r_rx_state || w_rx_tick)
            w_rx_cnt_n = '0;
        else
            w_rx_cnt_n = r_rx_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_frame_err  <= 1'b0;
            r_rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta    <= uart_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_state   <= w_rx_state_n;
            r_rx_cnt     <= w_rx_cnt_n;
            r_rx_idx     <= w_rx_idx_n;
            r_rx_shift   <= w_rx_shift_n;
            r_frame_err  <= w_frame_err_n;
            r_rx_overrun <= r_rx_overrun | (w_rx_push && w_rxf_full && !w_rx_pop);
`ifdef UART_PARITY_EN
            r_rx_par_bad <= w_rx_par_bad_n;
            r_parity_err <= w_parity_err_n;
`endif
        end
    end

endmodule
